// File: rtl/cell_renderer.sv
// cell_renderer
// Turns active-area pixel coordinates into cell line/column indices for the
// ant FSM's read address. Combines the returned cell colour with grid lines,
// the ant cell and its heading marker into a 12-bit RGB stream. DE and syncs
// are delayed so they stay aligned with the colour.
//
// Ports
//   iclk, irst_n            pixel clock, async active-low reset
//   ide, ihsync, ivsync     video timing in
//   ipix_x, ipix_y          active-area pixel coordinates (valid when ide=1)
//   oline, ocolumn          cell indices to the FSM, 1 cycle after the pixel
//   ird_data                cell colour from memory (1 = black), C_RD_LATENCY
//                           cycles after oline/ocolumn
//   icur_pos_x/y, idirection  ant position/heading (0 up,1 down,2 left,3 right)
//   orgb, ode, ohsync, ovsync  pixel out, C_RD_LATENCY+2 cycles after input
module cell_renderer #(
    parameter int C_NUM_OF_CELLS_X = 5,
    parameter int C_NUM_OF_CELLS_Y = 5,
    parameter int C_CELL_WIDTH     = 16,
    parameter int C_CELL_HEIGHT    = 16,
    parameter int C_RD_LATENCY     = 2,   // must be >= 1
    localparam int CW = $clog2((C_NUM_OF_CELLS_X + C_NUM_OF_CELLS_Y) / 2)
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          ide,
    input  logic          ihsync,
    input  logic          ivsync,
    input  logic [10:0]   ipix_x,
    input  logic [10:0]   ipix_y,
    output logic [CW-1:0] oline,
    output logic [CW-1:0] ocolumn,
    input  logic          ird_data,
    input  logic [CW-1:0] icur_pos_x,
    input  logic [CW-1:0] icur_pos_y,
    input  logic [1:0]    idirection,
    output logic [11:0]   orgb,
    output logic          ode,
    output logic          ohsync,
    output logic          ovsync
);

    localparam int SXW = (C_CELL_WIDTH  > 1) ? $clog2(C_CELL_WIDTH)  : 1;
    localparam int SYW = (C_CELL_HEIGHT > 1) ? $clog2(C_CELL_HEIGHT) : 1;
    localparam int L   = C_RD_LATENCY;

    localparam logic [SXW-1:0] SX_LAST = SXW'(C_CELL_WIDTH - 1);
    localparam logic [SYW-1:0] SY_LAST = SYW'(C_CELL_HEIGHT - 1);
    localparam logic [SXW-1:0] SX_EDGE = SXW'(C_CELL_WIDTH - 2);
    localparam logic [SYW-1:0] SY_EDGE = SYW'(C_CELL_HEIGHT - 2);
    localparam logic [CW-1:0]  COL_LAST = CW'(C_NUM_OF_CELLS_X - 1);
    localparam logic [CW-1:0]  ROW_LAST = CW'(C_NUM_OF_CELLS_Y - 1);

    typedef struct packed {
        logic ingrid;
        logic grid;
        logic ant;
        logic mark;
    } attr_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // stage 1 state
    logic [SXW-1:0] subx;
    logic [SYW-1:0] suby;
    logic           colv, rowv;
    logic [CW-1:0]  snap_x, snap_y;
    logic [1:0]     snap_dir;

    logic x0, y0;
    assign x0 = (ipix_x == 11'd0);
    assign y0 = (ipix_y == 11'd0);

    // Coordinate counters. Columns restart on every x==0; rows only restart
    // on the (0,0) pixel, so a reset mid-frame leaves rowv low until then.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            subx     <= '0;
            suby     <= '0;
            ocolumn  <= '0;
            oline    <= '0;
            colv     <= 1'b0;
            rowv     <= 1'b0;
            snap_x   <= '0;
            snap_y   <= '0;
            snap_dir <= '0;
        end else if (ide) begin
            if (x0) begin
                subx    <= '0;
                ocolumn <= '0;
                colv    <= 1'b1;
                if (y0) begin
                    suby     <= '0;
                    oline    <= '0;
                    rowv     <= 1'b1;
                    // ant state is frozen per frame to avoid tearing
                    snap_x   <= icur_pos_x;
                    snap_y   <= icur_pos_y;
                    snap_dir <= idirection;
                end else if (suby == SY_LAST) begin
                    suby <= '0;
                    if (oline == ROW_LAST) rowv  <= 1'b0;
                    else                   oline <= oline + 1'b1;
                end else begin
                    suby <= suby + 1'b1;
                end
            end else if (subx == SX_LAST) begin
                subx <= '0;
                if (ocolumn == COL_LAST) colv    <= 1'b0;
                else                     ocolumn <= ocolumn + 1'b1;
            end else begin
                subx <= subx + 1'b1;
            end
        end
    end

    // per-pixel attributes derived from stage 1, aligned later with ird_data
    attr_t attr_s1;
    always_comb begin
        attr_s1        = '0;
        attr_s1.ingrid = colv & rowv;
        attr_s1.grid   = (subx == '0) | (suby == '0);
        attr_s1.ant    = colv & rowv & (oline == snap_y) & (ocolumn == snap_x);
        unique case (snap_dir)
            2'd0:    attr_s1.mark = (suby < SYW'(2));
            2'd1:    attr_s1.mark = (suby >= SY_EDGE);
            2'd2:    attr_s1.mark = (subx < SXW'(2));
            default: attr_s1.mark = (subx >= SX_EDGE);
        endcase
    end

    // attr_pipe[L-1] lines up with ird_data; sync_pipe[L] lines up with both
    attr_t [L-1:0] attr_pipe;
    sync_t [L:0]   sync_pipe;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            attr_pipe <= '0;
            sync_pipe <= '0;
        end else begin
            attr_pipe[0] <= attr_s1;
            for (int i = 1; i < L; i++) attr_pipe[i] <= attr_pipe[i-1];
            sync_pipe[0] <= '{de: ide, hs: ihsync, vs: ivsync};
            for (int i = 1; i <= L; i++) sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    attr_t       a_d;
    sync_t       s_d;
    logic [11:0] rgb_next;

    assign a_d = attr_pipe[L-1];
    assign s_d = sync_pipe[L];

    // ird_data is taken as-is; stale data outside the FSM's read state is shown
    always_comb begin
        rgb_next = 12'h000;
        if (!s_d.de)                 rgb_next = 12'h000;
        else if (!a_d.ingrid)        rgb_next = 12'h008;
        else if (a_d.ant && a_d.mark) rgb_next = 12'hFF0;
        else if (a_d.ant)            rgb_next = 12'hF00;
        else if (a_d.grid)           rgb_next = 12'h444;
        else if (ird_data)           rgb_next = 12'h000;
        else                         rgb_next = 12'hFFF;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            orgb   <= 12'h000;
            ode    <= 1'b0;
            ohsync <= 1'b0;
            ovsync <= 1'b0;
        end else begin
            orgb   <= rgb_next;
            ode    <= s_d.de;
            ohsync <= s_d.hs;
            ovsync <= s_d.vs;
        end
    end

endmodule

// File: tb/tb_cell_renderer.sv
// Bench for cell_renderer: raster frames with random DE bubbles, random cell
// colour, ant moves mid-frame and a reset mid-frame. Expected pixels come from
// a divide/modulo model of the grid and are checked by a separate monitor.
module tb_cell_renderer;

    localparam int NX = 5, NY = 5, CELL_W = 16, CELL_H = 16, RDL = 2, CW = 3;
    localparam int ACT_W = 112, ACT_H = 90, HBL = 8, VBL = 3, NFRAMES = 4;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          ide = 1'b0, ihsync = 1'b0, ivsync = 1'b0;
    logic [10:0]   ipix_x = '0, ipix_y = '0;
    logic [CW-1:0] oline, ocolumn;
    logic          ird_data = 1'b0;
    logic [CW-1:0] icur_pos_x = '0, icur_pos_y = '0;
    logic [1:0]    idirection = '0;
    logic [11:0]   orgb;
    logic          ode, ohsync, ovsync;

    cell_renderer #(
        .C_NUM_OF_CELLS_X(NX), .C_NUM_OF_CELLS_Y(NY),
        .C_CELL_WIDTH(CELL_W), .C_CELL_HEIGHT(CELL_H), .C_RD_LATENCY(RDL)
    ) dut (
        .iclk(iclk), .irst_n(irst_n), .ide(ide), .ihsync(ihsync), .ivsync(ivsync),
        .ipix_x(ipix_x), .ipix_y(ipix_y), .oline(oline), .ocolumn(ocolumn),
        .ird_data(ird_data), .icur_pos_x(icur_pos_x), .icur_pos_y(icur_pos_y),
        .idirection(idirection), .orgb(orgb), .ode(ode), .ohsync(ohsync), .ovsync(ovsync)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int   x, y;
        logic de, hs, vs;
        logic rows_ok, cols_ok;
        int   ax, ay, adir;
    } pix_t;
    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        de, hs, vs;
        int          x, y;
    } exp_t;
    typedef struct {
        int due;
        int line, col;
        int x, y;
    } cexp_t;

    pix_t  pend[$];
    exp_t  qr[$];
    cexp_t qc[$];

    int   cyc = 0;
    int   n_vec = 0, n_fail = 0;
    int   rst_hold = 3;
    logic rows_ok = 1'b0, cols_ok = 1'b0;
    int   snap_x = 0, snap_y = 0, snap_dir = 0;
    int   cur_x = 0, cur_y = 0, cur_dir = 0;

    always @(posedge iclk) cyc <= cyc + 1;

    // Reference: a pixel's cell is simply its coordinate divided by the cell size.
    function automatic logic [11:0] ref_rgb(input pix_t p, input logic rd);
        int   col, row, sx, sy;
        logic ant, mark;
        if (!p.de) return 12'h000;
        col = p.x / CELL_W; row = p.y / CELL_H;
        sx  = p.x % CELL_W; sy  = p.y % CELL_H;
        if (!(p.rows_ok && p.cols_ok && col < NX && row < NY)) return 12'h008;
        ant = (col == p.ax) && (row == p.ay);
        case (p.adir)
            0:       mark = (sy < 2);
            1:       mark = (sy >= CELL_H - 2);
            2:       mark = (sx < 2);
            default: mark = (sx >= CELL_W - 2);
        endcase
        if (ant && mark)       return 12'hFF0;
        if (ant)               return 12'hF00;
        if (sx == 0 || sy == 0) return 12'h444;
        if (rd)                return 12'h000;
        return 12'hFFF;
    endfunction

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One pixel clock of stimulus; ird_data driven here belongs to the pixel
    // issued RDL+1 cycles earlier.
    task automatic issue(input logic de, input logic hs, input logic vs, input int x, input int y);
        pix_t p;
        exp_t e;
        cexp_t c;
        @(posedge iclk); #1;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) irst_n = 1'b1;
        end
        ide = de; ihsync = hs; ivsync = vs;
        ipix_x = 11'(x); ipix_y = 11'(y);
        icur_pos_x = CW'(cur_x); icur_pos_y = CW'(cur_y); idirection = 2'(cur_dir);
        ird_data = 1'($urandom_range(1));
        if (irst_n) begin
            if (de && x == 0) cols_ok = 1'b1;
            if (de && x == 0 && y == 0) begin
                rows_ok = 1'b1;
                snap_x = cur_x; snap_y = cur_y; snap_dir = cur_dir;
            end
            p.x = x; p.y = y; p.de = de; p.hs = hs; p.vs = vs;
            p.rows_ok = rows_ok; p.cols_ok = cols_ok;
            p.ax = snap_x; p.ay = snap_y; p.adir = snap_dir;
            pend.push_back(p);
            if (de && rows_ok && cols_ok) begin
                c.due  = cyc + 1;
                c.line = (y / CELL_H < NY - 1) ? y / CELL_H : NY - 1;
                c.col  = (x / CELL_W < NX - 1) ? x / CELL_W : NX - 1;
                c.x = x; c.y = y;
                qc.push_back(c);
            end
            if (pend.size() == RDL + 2) begin
                p = pend.pop_front();
                e.due = cyc + 1;
                e.rgb = ref_rgb(p, ird_data);
                e.de = p.de; e.hs = p.hs; e.vs = p.vs; e.x = p.x; e.y = p.y;
                qr.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        irst_n = 1'b0;
        #1;
        chk("rst_async_orgb", orgb, 12'h000);
        chk("rst_async_ode", 12'(ode), 12'h000);
        chk("rst_async_ohsync", 12'(ohsync), 12'h000);
        chk("rst_async_ovsync", 12'(ovsync), 12'h000);
        chk("rst_async_oline", 12'(oline), 12'h000);
        chk("rst_async_ocolumn", 12'(ocolumn), 12'h000);
        pend.delete(); qr.delete(); qc.delete();
        rows_ok = 1'b0; cols_ok = 1'b0;
        snap_x = 0; snap_y = 0; snap_dir = 0;
        rst_hold = 3;
    endtask

    // monitor: pops whatever is due this cycle and compares
    initial begin
        exp_t  e;
        cexp_t c;
        forever begin
            @(negedge iclk);
            while (qr.size() > 0 && qr[0].due < cyc) begin
                e = qr.pop_front(); n_vec++; n_fail++;
                $display("FAIL pix_missed (%0d,%0d) due=%0d now=%0d", e.x, e.y, e.due, cyc);
            end
            if (qr.size() > 0 && qr[0].due == cyc) begin
                e = qr.pop_front(); n_vec++;
                if (orgb !== e.rgb || ode !== e.de || ohsync !== e.hs || ovsync !== e.vs) begin
                    n_fail++;
                    $display("FAIL pix (%0d,%0d) got rgb=%h de=%b hs=%b vs=%b exp rgb=%h de=%b hs=%b vs=%b",
                             e.x, e.y, orgb, ode, ohsync, ovsync, e.rgb, e.de, e.hs, e.vs);
                end
            end
            while (qc.size() > 0 && qc[0].due < cyc) begin
                c = qc.pop_front(); n_vec++; n_fail++;
                $display("FAIL cell_missed (%0d,%0d)", c.x, c.y);
            end
            if (qc.size() > 0 && qc[0].due == cyc) begin
                c = qc.pop_front(); n_vec++;
                if (int'(oline) != c.line || int'(ocolumn) != c.col) begin
                    n_fail++;
                    $display("FAIL cell (%0d,%0d) got line=%0d col=%0d exp line=%0d col=%0d",
                             c.x, c.y, oline, ocolumn, c.line, c.col);
                end
            end
        end
    end

    initial begin
        logic hs, vs, act;
        #2;
        chk("reset_orgb", orgb, 12'h000);
        chk("reset_ode", 12'(ode), 12'h000);
        chk("reset_ohsync", 12'(ohsync), 12'h000);
        chk("reset_ovsync", 12'(ovsync), 12'h000);
        chk("reset_oline", 12'(oline), 12'h000);
        chk("reset_ocolumn", 12'(ocolumn), 12'h000);
        repeat (5) issue(1'b0, 1'b0, 1'b0, 0, 0);

        for (int f = 0; f < NFRAMES; f++) begin
            case (f)
                0:       begin cur_x = 2; cur_y = 2; cur_dir = 2; end
                1:       begin cur_x = 1; cur_y = 3; cur_dir = 3; end
                2:       begin cur_x = $urandom_range(4); cur_y = $urandom_range(4); cur_dir = 0; end
                default: begin cur_x = $urandom_range(4); cur_y = $urandom_range(4); cur_dir = 1; end
            endcase
            for (int y = 0; y < ACT_H + VBL; y++) begin
                for (int x = 0; x < ACT_W + HBL; x++) begin
                    act = (x < ACT_W) && (y < ACT_H);
                    hs  = (x >= ACT_W + 2) && (x < ACT_W + 6);
                    vs  = (y == ACT_H + 1);
                    // move the ant mid-frame; the display must keep the old spot
                    if (act && x == 0 && y == 40) begin
                        cur_x = (f == 0) ? 4 : $urandom_range(7);
                        cur_y = $urandom_range(7);
                        cur_dir = $urandom_range(3);
                    end
                    if (act && $urandom_range(15) == 0)
                        issue(1'b0, hs, vs, $urandom_range(2047), $urandom_range(2047));
                    if (act) issue(1'b1, hs, vs, x, y);
                    else     issue(1'b0, hs, vs, $urandom_range(2047), $urandom_range(2047));
                    if (f == 1 && y == 50 && x == 100) do_reset();
                end
            end
        end

        repeat (8) issue(1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (qr.size() == 0 && qc.size() == 0) break;
            @(negedge iclk);
        end
        if (qr.size() != 0 || qc.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL drain pending rgb=%0d cell=%0d exp 0", qr.size(), qc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_renderer.md
# cell_renderer

Pixel-side stage downstream of the ant FSM and its cell memory. It turns the video timing generator's pixel coordinates into the cell `line`/`column` indices that the FSM uses for its read address. It then takes the returned cell colour and produces a pipelined 12-bit RGB pixel stream with grid lines, the ant cell and its heading marker. Sync and data-enable are delayed to stay aligned with the colour.

## Interface
- `C_NUM_OF_CELLS_X`, 5: grid width in cells.
- `C_NUM_OF_CELLS_Y`, 5: grid height in cells.
- `C_CELL_WIDTH`, 16: cell width in pixels (≥4).
- `C_CELL_HEIGHT`, 16: cell height in pixels (≥4).
- `C_RD_LATENCY`, 2: cycles from `oline`/`ocolumn` valid to matching `ird_data` (one cycle for the FSM address register, one for the RAM read).
- Derived `CW = $clog2((C_NUM_OF_CELLS_X+C_NUM_OF_CELLS_Y)/2)`, the cell index width shared with the FSM.

Ports:
- `iclk` in 1: pixel clock, the only clock.
- `irst_n` in 1: asynchronous, active-low reset.
- `ide` in 1: active-video enable.
- `ihsync` in 1, `ivsync` in 1: syncs, passed through with delay.
- `ipix_x` in 11, `ipix_y` in 11: active-area pixel coordinates, valid when `ide`=1.
- `oline` out CW, `ocolumn` out CW: cell indices to the FSM.
- `ird_data` in 1: cell colour, 1 = black.
- `icur_pos_x` in CW, `icur_pos_y` in CW: ant position.
- `idirection` in 2: ant heading. 0 = up, 1 = down, 2 = left, 3 = right.
- `orgb` out 12: {R[3:0],G[3:0],B[3:0]}.
- `ode` out 1, `ohsync` out 1, `ovsync` out 1: delayed copies of the inputs.

## Operation
- Stage 1 (coordinate counters, registered), active when `ide`=1:
  - On `ipix_x`==0: `subx`←0, `ocolumn`←0, `colv`←1.
  - Otherwise `subx` increments. When `subx`==`C_CELL_WIDTH`-1: `subx`←0 and `ocolumn`++. If `ocolumn` was `C_NUM_OF_CELLS_X`-1, `colv`←0 and `ocolumn` holds.
  - On `ipix_x`==0 && `ipix_y`==0: `suby`←0, `oline`←0, `rowv`←1.
  - On `ipix_x`==0 && `ipix_y`≠0: `suby`/`oline`/`rowv` advance with the same wrap/saturate rule, using `C_CELL_HEIGHT` and `C_NUM_OF_CELLS_Y`.
  - `ingrid = colv & rowv`.
- Ant snapshot: on `ide` && `ipix_x`==0 && `ipix_y`==0, latch `icur_pos_x/y` and `idirection`. These hold for the whole frame (no tearing).
- Stage 1 also computes the following, all delayed `C_RD_LATENCY` cycles:
  - `grid` = (`subx`==0 | `suby`==0).
  - `ant` = `ingrid` & (`oline`,`ocolumn`)==snapshot.
  - `mark` = heading strip: up `suby`<2, down `suby`≥H-2, left `subx`<2, right `subx`≥W-2.
- Output stage: colour priority, first match wins:
  - delayed `ide`=0 → 0x000
  - !`ingrid` → 0x008
  - `ant`&`mark` → 0xFF0
  - `ant` → 0xF00
  - `grid` → 0x444
  - `ird_data`=1 → 0x000
  - else → 0xFFF
- `ird_data` is used as-is. If the FSM is outside its display-read state, stale data is shown; this is intended.

## Timing
- Total latency from input pixel to `orgb`/`ode`/`ohsync`/`ovsync` is `C_RD_LATENCY`+2 cycles (4 by default). All four outputs are aligned to the same pixel.
- `oline`/`ocolumn` appear 1 cycle after the pixel. `ird_data` is sampled `C_RD_LATENCY` cycles after that.
- Reset values: `orgb`=0, `ode`=0, `ohsync`=0, `ovsync`=0, `oline`=0, `ocolumn`=0. Counters, snapshot, `colv`/`rowv` and all delay registers also clear to 0.
- Reset mid-frame: `rowv`=0, so rows render out-of-grid (0x008) until the next frame start. Columns resync at the next `ipix_x`==0. No X propagates.
- `ide` low: counters hold, and the pipeline still shifts the delayed `ide`/syncs.
- A frame start and a changed `icur_pos` in the same cycle: the new value is latched.

## Test plan
- Reset, then 640×480 frame with 5×5 grid of 16×16 cells:
  - pixel (17,33) → `oline`=2, `ocolumn`=1 one cycle later.
  - `orgb` 4 cycles later; with `ird_data`=0 it is 0xFFF.
- Pixel (80,0) with cells X=5: `colv`=0 → `orgb`=0x008. Pixel (16,16) → grid 0x444.
- Ant at (2,2), direction=2 (left):
  - pixel (33,40) → 0xFF0.
  - pixel (40,40) → 0xF00.
  - `ird_data`=1 on a non-ant cell interior → 0x000.
- Change `icur_pos_x` mid-frame: rendering keeps the old position until the next (0,0) pixel.
- Assert `irst_n` low at pixel (100,50): all outputs 0 asynchronously. After release, rows are 0x008 until the next frame, then render normally.
- `ihsync`/`ivsync`/`ide` toggle patterns appear on the outputs delayed by exactly 4 cycles.
